// File: rtl/load_ctrl.sv
// load_ctrl: sequential load unit that issues a word-aligned read and extracts/extends LB/LBU/LH/LHU/LW.
// Optional feature: LOAD_MISALIGN_TRAP_EN builds the ERR state and traps misaligned LH/LHU/LW.

package rysyPkg;
    localparam int REG_LEN = 32;
endpackage

package selectPkg;
    typedef enum logic [3:0] {
        NONE,
        LB,
        LBU,
        LH,
        LHU,
        LW,
        SB,
        SH,
        SW
    } sel_type;
endpackage

module load_ctrl (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  selectPkg::sel_type            sel_type,
    input  logic [rysyPkg::REG_LEN-1:0]   addr,
    output logic                          busy,
    output logic                          mem_req,
    output logic [rysyPkg::REG_LEN-1:0]   mem_addr,
    input  logic                          mem_ready,
    input  logic [rysyPkg::REG_LEN-1:0]   mem_rdata,
    output logic [rysyPkg::REG_LEN-1:0]   rd_d,
    output logic                          done,
    output logic                          err
);

    localparam int REG_LEN = rysyPkg::REG_LEN;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
`ifdef LOAD_MISALIGN_TRAP_EN
        , ERR
`endif
    } StateT;

    StateT                r_state;
    StateT                w_nextState;
    selectPkg::sel_type   r_typeQ;
    logic [1:0]           r_offQ;
    logic [REG_LEN-1:0]   r_memAddr;
    logic [REG_LEN-1:0]   r_rdD;

    logic                 w_isLoad;
    logic                 w_misalign;
    logic                 w_accept;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [REG_LEN-1:0]   w_extract;

    always_comb begin
        w_isLoad = (sel_type == selectPkg::LB)  || (sel_type == selectPkg::LBU) ||
                   (sel_type == selectPkg::LH)  || (sel_type == selectPkg::LHU) ||
                   (sel_type == selectPkg::LW);
`ifdef LOAD_MISALIGN_TRAP_EN
        w_misalign = (((sel_type == selectPkg::LH) || (sel_type == selectPkg::LHU)) && addr[0]) ||
                     ((sel_type == selectPkg::LW) && (addr[1:0] != 2'b00));
`else
        w_misalign = 1'b0;
`endif
        w_accept = (r_state == IDLE) && start && w_isLoad && !w_misalign;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start && w_isLoad) begin
`ifdef LOAD_MISALIGN_TRAP_EN
                    w_nextState = w_misalign ? ERR : BUSY;
`else
                    w_nextState = BUSY;
`endif
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    w_nextState = DONE;
                end
            end
            DONE: w_nextState = IDLE;
`ifdef LOAD_MISALIGN_TRAP_EN
            ERR:  w_nextState = IDLE;
`endif
            default: w_nextState = IDLE;
        endcase
    end

    // Halfword selection only looks at off[1]; off[0] is irrelevant once aligned (or ignored when untrapped).
    always_comb begin
        case (r_offQ)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_offQ[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_typeQ)
            selectPkg::LB:  w_extract = {{(REG_LEN-8){w_byte[7]}}, w_byte};
            selectPkg::LBU: w_extract = {{(REG_LEN-8){1'b0}}, w_byte};
            selectPkg::LH:  w_extract = {{(REG_LEN-16){w_half[15]}}, w_half};
            selectPkg::LHU: w_extract = {{(REG_LEN-16){1'b0}}, w_half};
            default:        w_extract = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_typeQ   <= selectPkg::NONE;
            r_offQ    <= 2'b00;
            r_memAddr <= '0;
            r_rdD     <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_typeQ   <= sel_type;
                r_offQ    <= addr[1:0];
                r_memAddr <= {addr[REG_LEN-1:2], 2'b00};
            end
            if ((r_state == BUSY) && mem_ready) begin
                r_rdD <= w_extract;
            end
        end
    end

    // Outputs decode straight from the state register so reset drops them asynchronously.
    assign busy     = (r_state != IDLE);
    assign mem_req  = (r_state == BUSY);
    assign done     = (r_state == DONE);
    assign mem_addr = r_memAddr;
    assign rd_d     = r_rdD;
`ifdef LOAD_MISALIGN_TRAP_EN
    assign err      = (r_state == ERR);
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_load_ctrl.sv
// tb_load_ctrl: directed checks of load_ctrl against a one-word memory holding 0x8765F0A1 at 0x100.
module tb_load_ctrl;

    localparam logic [31:0] MEM_WORD = 32'h8765F0A1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    selectPkg::sel_type selType;
    logic [31:0]        addr;
    logic               busy;
    logic               memReq;
    logic [31:0]        memAddr;
    logic               memReady;
    logic [31:0]        memRdata;
    logic [31:0]        rdD;
    logic               done;
    logic               err;

    int checks = 0;
    int errors = 0;

    load_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sel_type  (selType),
        .addr      (addr),
        .busy      (busy),
        .mem_req   (memReq),
        .mem_addr  (memAddr),
        .mem_ready (memReady),
        .mem_rdata (memRdata),
        .rd_d      (rdD),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    assign memRdata = (memAddr == 32'h100) ? MEM_WORD : 32'h0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one load at a negedge, holds mem_ready low for 'delay' BUSY cycles, then checks the result.
    task automatic applyStimulus(input selectPkg::sel_type t, input logic [31:0] a, input int delay,
                                 input bit startInBusy, input logic [31:0] expAddr,
                                 input logic [31:0] expRd, input string tag);
        start   = 1'b1;
        selType = t;
        addr    = a;
        @(negedge clk);
        start = 1'b0;
        addr  = 32'h200;
        for (int i = 0; i <= delay; i++) begin
            checkOutput({tag, ".busy"},    busy,    32'd1);
            checkOutput({tag, ".memReq"},  memReq,  32'd1);
            checkOutput({tag, ".memAddr"}, memAddr, expAddr);
            checkOutput({tag, ".noDone"},  done,    32'd0);
            checkOutput({tag, ".noErr"},   err,     32'd0);
            memReady = (i == delay);
            start    = startInBusy && (i == 1);
            @(negedge clk);
        end
        memReady = 1'b0;
        start    = 1'b0;
        checkOutput({tag, ".done"},      done,   32'd1);
        checkOutput({tag, ".reqDrop"},   memReq, 32'd0);
        checkOutput({tag, ".rdD"},       rdD,    expRd);
        checkOutput({tag, ".doneErr"},   err,    32'd0);
        @(negedge clk);
        checkOutput({tag, ".doneOnce"},  done,   32'd0);
        checkOutput({tag, ".idle"},      busy,   32'd0);
        checkOutput({tag, ".rdHold"},    rdD,    expRd);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        selType  = selectPkg::NONE;
        addr     = 32'h0;
        memReady = 1'b0;

        @(negedge clk);
        checkOutput("rst.busy",    busy,    32'd0);
        checkOutput("rst.memReq",  memReq,  32'd0);
        checkOutput("rst.memAddr", memAddr, 32'd0);
        checkOutput("rst.rdD",     rdD,     32'd0);
        checkOutput("rst.done",    done,    32'd0);
        checkOutput("rst.err",     err,     32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        start   = 1'b1;
        selType = selectPkg::SW;
        addr    = 32'h100;
        @(negedge clk);
        start = 1'b0;
        checkOutput("notLoad.busy",   busy,   32'd0);
        checkOutput("notLoad.memReq", memReq, 32'd0);

        memReady = 1'b1;
        @(negedge clk);
        memReady = 1'b0;
        checkOutput("idleReady.done", done, 32'd0);
        checkOutput("idleReady.busy", busy, 32'd0);
        checkOutput("idleReady.rdD",  rdD,  32'd0);

        applyStimulus(selectPkg::LB,  32'h103, 0, 1'b0, 32'h100, 32'hFFFFFF87, "lb103");
        applyStimulus(selectPkg::LBU, 32'h100, 0, 1'b0, 32'h100, 32'h000000A1, "lbu100");
        applyStimulus(selectPkg::LBU, 32'h101, 1, 1'b0, 32'h100, 32'h000000F0, "lbu101");
        applyStimulus(selectPkg::LH,  32'h102, 0, 1'b0, 32'h100, 32'hFFFF8765, "lh102");
        applyStimulus(selectPkg::LHU, 32'h100, 0, 1'b0, 32'h100, 32'h0000F0A1, "lhu100");
        applyStimulus(selectPkg::LH,  32'h100, 2, 1'b0, 32'h100, 32'hFFFFF0A1, "lh100");
        applyStimulus(selectPkg::LW,  32'h100, 3, 1'b1, 32'h100, MEM_WORD,     "lwWait");
        checkOutput("lwWait.noRestart", busy, 32'd0);

        start   = 1'b1;
        selType = selectPkg::LW;
        addr    = 32'h100;
        @(negedge clk);
        start = 1'b0;
        checkOutput("abort.busyBefore", memReq, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort.busy",    busy,    32'd0);
        checkOutput("abort.memReq",  memReq,  32'd0);
        checkOutput("abort.memAddr", memAddr, 32'd0);
        checkOutput("abort.rdD",     rdD,     32'd0);
        checkOutput("abort.done",    done,    32'd0);
        memReady = 1'b1;
        @(negedge clk);
        memReady = 1'b0;
        checkOutput("abort.noDone1", done, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort.noDone2", done, 32'd0);
        checkOutput("abort.idle",    busy, 32'd0);
        applyStimulus(selectPkg::LW, 32'h100, 1, 1'b0, 32'h100, MEM_WORD, "lwAfterRst");

`ifdef LOAD_MISALIGN_TRAP_EN
        start   = 1'b1;
        selType = selectPkg::LW;
        addr    = 32'h101;
        @(negedge clk);
        start = 1'b0;
        checkOutput("mis.err",    err,    32'd1);
        checkOutput("mis.memReq", memReq, 32'd0);
        checkOutput("mis.busy",   busy,   32'd1);
        checkOutput("mis.rdD",    rdD,    MEM_WORD);
        @(negedge clk);
        checkOutput("mis.errOnce", err,    32'd0);
        checkOutput("mis.memReq2", memReq, 32'd0);
        checkOutput("mis.idle",    busy,   32'd0);
        checkOutput("mis.noDone",  done,   32'd0);
`else
        applyStimulus(selectPkg::LW, 32'h101, 0, 1'b0, 32'h100, MEM_WORD, "lw101");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
